// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline register stage with registered upstream ready.
// Keeps full throughput while cutting the ready path between neighbouring stages.
module pipe_stage_skid #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int CTRL_W = 5,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [RD_W-1:0]   rd_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [RD_W-1:0]   rd_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
    logic [RD_W-1:0]   rd;
  } beat_t;

  state_t           state_q, state_d;
  beat_t            main_q, main_d;
  beat_t            skid_q, skid_d;
  logic             rdy_q, rdy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  beat_t in_beat;
  logic  dn_valid;
  logic  up_fire;
  logic  dn_fire;

  assign in_beat  = '{pc: pc_i, data: data_i, ctrl: ctrl_i, rd: rd_i};
  assign dn_valid = (state_q != EMPTY);
  assign up_fire  = up_valid_i & rdy_q;
  assign dn_fire  = dn_valid & dn_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (up_fire) begin
          state_d = ONE;
          main_d  = in_beat;
        end
      end
      ONE: begin
        if (up_fire && dn_fire) begin
          main_d = in_beat;
        end else if (up_fire) begin
          state_d = TWO;
          skid_d  = in_beat;
        end else if (dn_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (dn_fire) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush beats any load; held payload stays put so outputs remain stable.
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
    rdy_d = (state_d != TWO);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (dn_valid && !dn_ready_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign up_ready_o  = rdy_q;
  assign dn_valid_o  = dn_valid;
  assign pc_o        = main_q.pc;
  assign data_o      = main_q.data;
  assign ctrl_o      = dn_valid ? main_q.ctrl : '0;
  assign rd_o        = main_q.rd;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: streaming, backpressure, flush,
// bubble gating, async reset and stall-counter saturation (CNT_W=4).
module tb_pipe_stage_skid;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        up_valid;
  logic        up_ready;
  logic [31:0] pc_in;
  logic [31:0] data_in;
  logic [4:0]  ctrl_in;
  logic [4:0]  rd_in;
  logic        dn_valid;
  logic        dn_ready;
  logic [31:0] pc_out;
  logic [31:0] data_out;
  logic [4:0]  ctrl_out;
  logic [4:0]  rd_out;
  logic [3:0]  stall;

  int n_cmp = 0;
  int n_err = 0;

  pipe_stage_skid #(
    .PC_W(32), .DATA_W(32), .CTRL_W(5), .RD_W(5), .CNT_W(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .flush_i(flush),
    .up_valid_i(up_valid),
    .up_ready_o(up_ready),
    .pc_i(pc_in),
    .data_i(data_in),
    .ctrl_i(ctrl_in),
    .rd_i(rd_in),
    .dn_valid_o(dn_valid),
    .dn_ready_i(dn_ready),
    .pc_o(pc_out),
    .data_o(data_out),
    .ctrl_o(ctrl_out),
    .rd_o(rd_out),
    .stall_cnt_o(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    up_valid = v;
    pc_in    = pc;
    data_in  = pc ^ 32'hA5A5_0000;
    rd_in    = pc[6:2];
    ctrl_in  = 5'b10110;
  endtask

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    dn_ready = 1'b0;
    drive(1'b0, 32'h0);
    #12;
    chk("rst_valid", {63'd0, dn_valid}, 64'd0);
    chk("rst_ready", {63'd0, up_ready}, 64'd1);
    chk("rst_pc", {32'd0, pc_out}, 64'd0);
    chk("rst_ctrl", {59'd0, ctrl_out}, 64'd0);
    chk("rst_stall", {60'd0, stall}, 64'd0);
    rst = 1'b0;

    // streaming
    dn_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      drive(1'b1, 32'h100 + 32'(4 * n));
      step();
      chk("str_pc", {32'd0, pc_out}, 64'h100 + 64'(4 * n));
      chk("str_valid", {63'd0, dn_valid}, 64'd1);
      chk("str_ready", {63'd0, up_ready}, 64'd1);
    end
    chk("str_data", {32'd0, data_out}, 64'h A5A5_011C);
    chk("str_ctrl", {59'd0, ctrl_out}, 64'b10110);
    chk("str_stall", {60'd0, stall}, 64'd0);

    // bubble
    drive(1'b0, 32'h0);
    ctrl_in = 5'b11111;
    step();
    chk("bub_valid", {63'd0, dn_valid}, 64'd0);
    chk("bub_ctrl", {59'd0, ctrl_out}, 64'd0);
    step();
    chk("bub_ctrl2", {59'd0, ctrl_out}, 64'd0);

    // backpressure
    dn_ready = 1'b0;
    drive(1'b1, 32'h200);
    step();
    chk("bp_a_pc", {32'd0, pc_out}, 64'h200);
    chk("bp_a_rdy", {63'd0, up_ready}, 64'd1);
    drive(1'b1, 32'h204);
    step();
    chk("bp_two_rdy", {63'd0, up_ready}, 64'd0);
    chk("bp_two_pc", {32'd0, pc_out}, 64'h200);
    drive(1'b0, 32'h0);
    step();
    chk("bp_hold_pc", {32'd0, pc_out}, 64'h200);
    chk("bp_hold_rdy", {63'd0, up_ready}, 64'd0);
    chk("bp_stall", {60'd0, stall}, 64'd2);
    dn_ready = 1'b1;
    step();
    chk("bp_b_pc", {32'd0, pc_out}, 64'h204);
    chk("bp_b_rd", {59'd0, rd_out}, 64'd1);
    chk("bp_b_valid", {63'd0, dn_valid}, 64'd1);
    chk("bp_b_rdy", {63'd0, up_ready}, 64'd1);
    step();
    chk("bp_empty", {63'd0, dn_valid}, 64'd0);
    chk("bp_stall2", {60'd0, stall}, 64'd2);

    // flush with simultaneous load
    dn_ready = 1'b0;
    drive(1'b1, 32'h300);
    step();
    drive(1'b1, 32'h304);
    step();
    chk("fl_two_rdy", {63'd0, up_ready}, 64'd0);
    flush = 1'b1;
    drive(1'b1, 32'h308);
    step();
    flush = 1'b0;
    chk("fl_valid", {63'd0, dn_valid}, 64'd0);
    chk("fl_ctrl", {59'd0, ctrl_out}, 64'd0);
    chk("fl_rdy", {63'd0, up_ready}, 64'd1);
    chk("fl_stall", {60'd0, stall}, 64'd4);
    drive(1'b0, 32'h0);
    dn_ready = 1'b1;
    step();
    chk("fl_gone", {63'd0, dn_valid}, 64'd0);
    drive(1'b1, 32'h30C);
    step();
    chk("fl_next_pc", {32'd0, pc_out}, 64'h30C);
    drive(1'b0, 32'h0);
    step();
    chk("fl_drain", {63'd0, dn_valid}, 64'd0);

    // async reset while in TWO
    dn_ready = 1'b0;
    drive(1'b1, 32'h400);
    step();
    drive(1'b1, 32'h404);
    step();
    drive(1'b0, 32'h0);
    chk("ar_pre_rdy", {63'd0, up_ready}, 64'd0);
    chk("ar_pre_stall", {60'd0, stall}, 64'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_pc", {32'd0, pc_out}, 64'd0);
    chk("ar_data", {32'd0, data_out}, 64'd0);
    chk("ar_ctrl", {59'd0, ctrl_out}, 64'd0);
    chk("ar_valid", {63'd0, dn_valid}, 64'd0);
    chk("ar_rdy", {63'd0, up_ready}, 64'd1);
    chk("ar_stall", {60'd0, stall}, 64'd0);
    #1;
    rst = 1'b0;
    step();
    chk("ar_after", {63'd0, dn_valid}, 64'd0);

    // stall counter saturation
    drive(1'b1, 32'h500);
    step();
    drive(1'b0, 32'h0);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) chk("sat_14", {60'd0, stall}, 64'd14);
    end
    chk("sat_max", {60'd0, stall}, 64'hF);
    chk("sat_pc", {32'd0, pc_out}, 64'h500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Parameters
REQ-001 The block SHALL have parameter PC_W, default 32, meaning instruction-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning result-data width.
REQ-003 The block SHALL have parameter CTRL_W, default 5, meaning control-bundle width (Branch, MemRead, MemtoReg, MemWrite, RegWrite).
REQ-004 The block SHALL have parameter RD_W, default 5, meaning destination-register-address width.
REQ-005 The block SHALL have parameter CNT_W, default 16, meaning stall-counter width.

Interface
REQ-006 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-008 The block SHALL have port flush_i, input, 1 bit: discard all held and incoming beats.
REQ-009 The block SHALL have ports up_valid_i (input, 1) and up_ready_o (output, 1): the upstream handshake.
REQ-010 The block SHALL have payload inputs pc_i (input, PC_W), data_i (input, DATA_W), ctrl_i (input, CTRL_W) and rd_i (input, RD_W).
REQ-011 The block SHALL have ports dn_valid_o (output, 1) and dn_ready_i (input, 1): the downstream handshake.
REQ-012 The block SHALL have payload outputs pc_o (output, PC_W), data_o (output, DATA_W), ctrl_o (output, CTRL_W) and rd_o (output, RD_W).
REQ-013 The block SHALL have port stall_cnt_o, output, CNT_W bits: count of downstream-stall cycles.

Function
REQ-014 The block SHALL hold two entries, MAIN (drives the outputs) and SKID, with states EMPTY (none), ONE (MAIN only) and TWO (MAIN+SKID).
REQ-015 The block SHALL register up_ready_o, driven 1 in EMPTY and ONE and 0 in TWO; it SHALL NOT depend combinationally on dn_ready_i.
REQ-016 An upstream transfer SHALL occur when up_valid_i & up_ready_o, and a downstream transfer when dn_valid_o & dn_ready_i.
REQ-017 dn_valid_o SHALL be 1 exactly in states ONE and TWO.
REQ-018 Transitions: EMPTY + up transfer -> ONE, with the beat loaded into MAIN (latency 1 cycle, input to output).
REQ-019 Transitions: ONE + up and dn transfer -> ONE, with MAIN reloaded; ONE + up only -> TWO, with the beat into SKID; ONE + dn only -> EMPTY.
REQ-020 Transitions: TWO + dn transfer -> ONE, with SKID moved to MAIN; no up transfer is possible in TWO.
REQ-021 Beats SHALL leave in arrival order, with no duplication and no loss, except under flush.
REQ-022 While dn_valid_o=0, ctrl_o SHALL be all-zero so that a bubble never writes a register or memory; pc_o, data_o and rd_o are don't-care but stable.
REQ-023 Output payload SHALL change only on a downstream transfer or on a load into EMPTY; it SHALL be held stable while dn_valid_o=1 and dn_ready_i=0.
REQ-024 flush_i=1 at an edge SHALL force state EMPTY, discard any concurrent upstream beat (flush wins over load), and set up_ready_o=1 at the next cycle.
REQ-025 flush_i SHALL NOT suppress a downstream transfer occurring in the same cycle; that beat counts as consumed.
REQ-026 stall_cnt_o SHALL increment by 1 each cycle in which dn_valid_o=1 and dn_ready_i=0.
REQ-027 stall_cnt_o SHALL saturate at 2^CNT_W-1, and SHALL be unaffected by flush_i.

Reset
REQ-028 While rst_i=1, the block SHALL asynchronously force state EMPTY, all payload outputs to 0, dn_valid_o=0, up_ready_o=1 and stall_cnt_o=0.
REQ-029 Reset asserted mid-operation SHALL drop all held beats; the first edge after rst_i falls SHALL obey the normal rules.

Verification
REQ-030 Bench scenario, streaming: dn_ready_i=1, issue 8 beats with pc=0x100+4n back-to-back -> pc_o matches 0x100..0x11C one cycle later each; up_ready_o stays 1; stall_cnt_o=0.
REQ-031 Bench scenario, backpressure: hold dn_ready_i=0 and send beats A and B -> state TWO, up_ready_o=0, pc_o=A held; raise dn_ready_i -> A then B delivered in order; stall_cnt_o equals the stalled cycle count.
REQ-032 Bench scenario, flush with simultaneous load: state TWO, pulse flush_i with up_valid_i=1 -> next cycle dn_valid_o=0, ctrl_o=0, up_ready_o=1; the flushed beat never appears at the output.
REQ-033 Bench scenario, bubble: up_valid_i=0 with ctrl_i=5'b11111 -> ctrl_o=0 and dn_valid_o=0.
REQ-034 Bench scenario, saturation: CNT_W=4 with 20 stall cycles -> stall_cnt_o=0xF.
REQ-035 Bench scenario, async reset: assert rst_i between clock edges while in TWO -> outputs zero and up_ready_o=1 immediately, without waiting for a clock edge.
